// File: rtl/fpu_mul_gen.sv
// Parametrised IEEE-754 binary multiplier with valid/ready handshakes on both sides,
// four run-time rounding modes and {invalid, overflow, underflow, inexact} flags.
// One operation in flight. The result appears five edges after the accept edge for
// every operand class.
module fpu_mul_gen #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [1:0]   rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int BIAS  = 2 ** (EXP_W - 1) - 1;
  localparam int EW    = EXP_W + 3;      // signed working exponent width
  localparam int MW    = MAN_W + 1;      // mantissa including hidden bit
  localparam int PW    = 2 * MW;         // full product width
  localparam int SHMAX = MAN_W + 3;      // enough to push the whole mantissa into sticky

  localparam logic signed [EW-1:0] EMIN    = EW'(2 - 2 ** (EXP_W - 1));
  localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
  localparam logic signed [EW-1:0] SHMAX_S = EW'(SHMAX);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0] MAN_ONES = '1;
  localparam logic [MAN_W-1:0] MAN_ZERO = '0;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StUnpack, StMul, StNorm, StRound, StDone} state_t;

  typedef struct packed {
    logic                 s;
    logic [MW-1:0]        m;
    logic signed [EW-1:0] e;
    logic                 zero;
    logic                 inf;
    logic                 nan;
    logic                 snan;
  } opnd_t;

  // Subnormals are left-normalised here so the multiplier only ever sees 1.x mantissas.
  function automatic opnd_t unpack(input logic [W-1:0] x);
    opnd_t            o;
    logic [EXP_W-1:0] ef;
    logic [MW-1:0]    mw;
    int               lzc;
    ef     = x[W-2:MAN_W];
    mw     = {1'b0, x[MAN_W-1:0]};
    o.s    = x[W-1];
    o.zero = (ef == '0) && (mw == '0);
    o.inf  = (ef == EXP_ONES) && (mw == '0);
    o.nan  = (ef == EXP_ONES) && (mw != '0);
    o.snan = o.nan && !mw[MAN_W-1];
    lzc = MW;
    for (int i = 0; i < MW; i++) begin
      if (mw[i]) lzc = MW - 1 - i;
    end
    if (ef == '0) begin
      o.m = mw << lzc;
      o.e = EMIN - EW'(lzc);
    end else begin
      o.m = {1'b1, x[MAN_W-1:0]};
      o.e = EW'(ef) - BIAS_S;
    end
    return o;
  endfunction

  state_t               state_q;
  logic [W-1:0]         a_q, b_q;
  logic [1:0]           rnd_q;
  logic                 sign_q;
  logic [MW-1:0]        m1_q, m2_q, man_q;
  logic signed [EW-1:0] e1_q, e2_q, exp_q;
  logic                 byp_q;
  logic [W-1:0]         byp_val_q;
  logic [3:0]           byp_flags_q;
  logic [PW-1:0]        prod_q;
  logic                 g_q, r_q, s_q, tiny_q, inexact_q, uf_q;

  opnd_t                u1, u2;
  logic                 byp_d;
  logic [W-1:0]         byp_val_d;
  logic [3:0]           byp_flags_d;

  logic [PW-1:0]        n_prod;
  logic signed [EW-1:0] n_exp, n_diff, exp_nd;
  int                   n_sh;
  logic [PW+SHMAX-1:0]  n_ext;
  logic [MW-1:0]        man_d;
  logic                 g_d, r_d, st_d, tiny_d;

  logic                 grs, inc;
  logic [MW:0]          sum;
  logic [MW-1:0]        man_r;
  logic signed [EW-1:0] exp_r;

  logic                 ovf, to_inf;
  logic [EXP_W-1:0]     exp_f;
  logic [W-1:0]         res_d;
  logic [3:0]           flg_d;

  // Classify captured operands and resolve special-case results into the bypass path.
  always_comb begin
    u1          = unpack(a_q);
    u2          = unpack(b_q);
    byp_d       = 1'b1;
    byp_val_d   = QNAN;
    byp_flags_d = 4'b0000;
    if (u1.nan || u2.nan) begin
      byp_flags_d = {u1.snan | u2.snan, 3'b000};
    end else if ((u1.inf && u2.zero) || (u1.zero && u2.inf)) begin
      byp_flags_d = 4'b1000;
    end else if (u1.inf || u2.inf) begin
      byp_val_d = {u1.s ^ u2.s, EXP_ONES, MAN_ZERO};
    end else if (u1.zero || u2.zero) begin
      byp_val_d = {u1.s ^ u2.s, {(W-1){1'b0}}};
    end else begin
      byp_d = 1'b0;
    end
  end

  // Bring the hidden bit to the product MSB, denormalise tiny results, extract G/R/S.
  always_comb begin
    n_prod = prod_q[PW-1] ? prod_q : {prod_q[PW-2:0], 1'b0};
    n_exp  = exp_q + EW'(prod_q[PW-1]);
    tiny_d = n_exp < EMIN;
    n_diff = EMIN - n_exp;
    n_sh   = 0;
    if (tiny_d) n_sh = (n_diff > SHMAX_S) ? SHMAX : int'(n_diff);
    n_ext  = {n_prod, {SHMAX{1'b0}}} >> n_sh;
    man_d  = n_ext[PW+SHMAX-1 -: MW];
    g_d    = n_ext[PW+SHMAX-1-MW];
    r_d    = n_ext[PW+SHMAX-2-MW];
    st_d   = |n_ext[PW+SHMAX-3-MW:0];
    exp_nd = tiny_d ? EMIN : n_exp;
  end

  // Apply the selected rounding mode; a carry-out renormalises by one place.
  always_comb begin
    grs = g_q | r_q | s_q;
    inc = 1'b0;
    case (rnd_q)
      2'b00:   inc = g_q & (r_q | s_q | man_q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = sign_q & grs;
      default: inc = ~sign_q & grs;
    endcase
    sum = {1'b0, man_q} + {{MW{1'b0}}, inc};
    if (sum[MW]) begin
      man_r = sum[MW:1];
      exp_r = exp_q + EW'(1);
    end else begin
      man_r = sum[MW-1:0];
      exp_r = exp_q;
    end
  end

  // Assemble the final word: bypass, overflow saturation by mode, or the rounded value.
  always_comb begin
    ovf    = exp_q > BIAS_S;
    to_inf = (rnd_q == 2'b00) | ((rnd_q == 2'b10) & sign_q) | ((rnd_q == 2'b11) & ~sign_q);
    // A cleared hidden bit means subnormal (or zero), which encodes with a zero exponent.
    exp_f  = man_q[MAN_W] ? EXP_W'(exp_q + BIAS_S) : '0;
    res_d  = {sign_q, exp_f, man_q[MAN_W-1:0]};
    flg_d  = {2'b00, uf_q, inexact_q};
    if (byp_q) begin
      res_d = byp_val_q;
      flg_d = byp_flags_q;
    end else if (ovf) begin
      flg_d = 4'b0101;
      res_d = to_inf ? {sign_q, EXP_ONES, MAN_ZERO} : {sign_q, EXP_MAXF, MAN_ONES};
    end
  end

  // Control FSM and all datapath registers; outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      flags       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rnd_q       <= '0;
      sign_q      <= 1'b0;
      m1_q        <= '0;
      m2_q        <= '0;
      man_q       <= '0;
      e1_q        <= '0;
      e2_q        <= '0;
      exp_q       <= '0;
      byp_q       <= 1'b0;
      byp_val_q   <= '0;
      byp_flags_q <= '0;
      prod_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      tiny_q      <= 1'b0;
      inexact_q   <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= din1;
            b_q      <= din2;
            rnd_q    <= rnd_mode;
            in_ready <= 1'b0;
            state_q  <= StUnpack;
          end
        end
        StUnpack: begin
          m1_q        <= u1.m;
          m2_q        <= u2.m;
          e1_q        <= u1.e;
          e2_q        <= u2.e;
          sign_q      <= u1.s ^ u2.s;
          byp_q       <= byp_d;
          byp_val_q   <= byp_val_d;
          byp_flags_q <= byp_flags_d;
          state_q     <= StMul;
        end
        StMul: begin
          prod_q  <= PW'(m1_q) * PW'(m2_q);
          exp_q   <= e1_q + e2_q;
          state_q <= StNorm;
        end
        StNorm: begin
          man_q   <= man_d;
          exp_q   <= exp_nd;
          g_q     <= g_d;
          r_q     <= r_d;
          s_q     <= st_d;
          tiny_q  <= tiny_d;
          state_q <= StRound;
        end
        StRound: begin
          man_q     <= man_r;
          exp_q     <= exp_r;
          inexact_q <= grs;
          uf_q      <= tiny_q & grs;
          state_q   <= StDone;
        end
        StDone: begin
          // First DONE cycle packs the result; it is then held until taken.
          if (!out_valid) begin
            result    <= res_d;
            flags     <= flg_d;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_gen.sv
// Self-checking bench for fpu_mul_gen: single-precision and half-precision instances,
// expected results queued at issue time and compared when each result is taken.
module tb_fpu_mul_gen;

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RDN = 2'b10;
  localparam logic [1:0] RUP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] din1 = '0, din2 = '0, result;
  logic [1:0]  rnd_mode = '0;
  logic [3:0]  flags;

  logic        in_valid_h = 1'b0, in_ready_h, out_valid_h;
  logic [15:0] din1_h = '0, din2_h = '0, result_h;
  logic [1:0]  rnd_mode_h = '0;
  logic [3:0]  flags_h;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t sbh[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  m;
    logic [31:0] res;
    logic [3:0]  flg;
    string       tag;
  } vec_t;

  fpu_mul_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din1      (din1),
    .din2      (din2),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  fpu_mul_gen #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_h),
    .in_ready  (in_ready_h),
    .din1      (din1_h),
    .din2      (din2_h),
    .rnd_mode  (rnd_mode_h),
    .out_valid (out_valid_h),
    .out_ready (out_ready),
    .result    (result_h),
    .flags     (flags_h)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one operand pair to the single-precision DUT; returns after the accept edge.
  task automatic issue(input vec_t v, input bit push);
    int n = 0;
    @(negedge clk);
    din1 = v.a; din2 = v.b; rnd_mode = v.m; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({v.tag, "/accept_timeout"}, 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{res: v.res, flg: v.flg, acc: cyc + 1, tag: v.tag});
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the DUT must ignore them.
    in_valid = 1'b0; din1 = $urandom; din2 = $urandom; rnd_mode = 2'($urandom);
  endtask

  task automatic issue_h(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                         input logic [15:0] res, input logic [3:0] flg, input string tag);
    int n = 0;
    @(negedge clk);
    din1_h = a; din2_h = b; rnd_mode_h = m; in_valid_h = 1'b1;
    while (!in_ready_h && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_h) begin
      check({tag, "/accept_timeout"}, 64'(in_ready_h), 64'(1));
      in_valid_h = 1'b0;
      return;
    end
    sbh.push_back('{res: 32'(res), flg: flg, acc: cyc + 1, tag: tag});
    @(posedge clk);
    #1;
    in_valid_h = 1'b0; din1_h = 16'($urandom); din2_h = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || sbh.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size() + sbh.size()), 64'(0));
  endtask

  // Single-precision monitor: latency on the rising edge of out_valid, data on handshake.
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && !seen) begin
          if (sb.size() == 0) check("unexpected_out", 64'(out_valid), 64'(0));
          else check({sb[0].tag, "/latency"}, 64'(cyc - sb[0].acc), 64'(5));
        end
        seen = out_valid;
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          check({e.tag, "/result"}, 64'(result), 64'(e.res));
          check({e.tag, "/flags"}, 64'(flags), 64'(e.flg));
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  // Half-precision monitor.
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid_h && !seen) begin
          if (sbh.size() == 0) check("h_unexpected_out", 64'(out_valid_h), 64'(0));
          else check({sbh[0].tag, "/latency"}, 64'(cyc - sbh[0].acc), 64'(5));
        end
        seen = out_valid_h;
        if (out_valid_h && out_ready && sbh.size() != 0) begin
          e = sbh.pop_front();
          check({e.tag, "/result"}, 64'(result_h), 64'(e.res));
          check({e.tag, "/flags"}, 64'(flags_h), 64'(e.flg));
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[] = '{
      '{32'h40400000, 32'h40000000, RNE, 32'h40C00000, 4'b0000, "mul_3x2"},
      '{32'h7F800000, 32'h00000000, RNE, 32'h7FC00000, 4'b1000, "inf_x_zero"},
      '{32'h00000000, 32'hFF800000, RNE, 32'h7FC00000, 4'b1000, "zero_x_ninf"},
      '{32'hFF800000, 32'h40000000, RNE, 32'hFF800000, 4'b0000, "ninf_x_2"},
      '{32'h7F800001, 32'h3F800000, RNE, 32'h7FC00000, 4'b1000, "snan"},
      '{32'h3F800000, 32'h7FC00001, RNE, 32'h7FC00000, 4'b0000, "qnan"},
      '{32'h80000000, 32'h40000000, RNE, 32'h80000000, 4'b0000, "nzero_x_2"},
      '{32'h7F7FFFFF, 32'h40000000, RNE, 32'h7F800000, 4'b0101, "ovf_rne"},
      '{32'h7F7FFFFF, 32'h40000000, RTZ, 32'h7F7FFFFF, 4'b0101, "ovf_rtz"},
      '{32'hFF7FFFFF, 32'h40000000, RUP, 32'hFF7FFFFF, 4'b0101, "ovf_rup_neg"},
      '{32'hFF7FFFFF, 32'h40000000, RDN, 32'hFF800000, 4'b0101, "ovf_rdn_neg"},
      '{32'h3F800001, 32'h3F800001, RNE, 32'h3F800002, 4'b0001, "inexact_rne"},
      '{32'h3F800001, 32'h3F800001, RUP, 32'h3F800003, 4'b0001, "inexact_rup"},
      '{32'h00800001, 32'h3F000000, RNE, 32'h00400000, 4'b0011, "sub_tie_even"},
      '{32'h00800000, 32'h3F000000, RNE, 32'h00400000, 4'b0000, "sub_exact"},
      '{32'h00000001, 32'h00000001, RNE, 32'h00000000, 4'b0011, "tiny_rne"},
      '{32'h00000001, 32'h00000001, RUP, 32'h00000001, 4'b0011, "tiny_rup"}
    };
    vec_t hold_v = '{32'h40400000, 32'h40000000, RNE, 32'h40C00000, 4'b0000, "hold"};
    vec_t rst_v  = '{32'h3F800000, 32'h3F800000, RNE, 32'h3F800000, 4'b0000, "rst_abort"};
    int   n;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst/in_ready", 64'(in_ready), 64'(1));
    check("rst/out_valid", 64'(out_valid), 64'(0));
    check("rst/result", 64'(result), 64'(0));
    check("rst/flags", 64'(flags), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) issue(vecs[i], 1'b1);
    wait_drain();

    // Result must stay put while the consumer stalls.
    @(negedge clk);
    out_ready = 1'b0;
    issue(hold_v, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold/result", 64'(result), 64'(32'h40C00000));
      check("hold/in_ready", 64'(in_ready), 64'(0));
      check("hold/out_valid", 64'(out_valid), 64'(1));
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset mid-operation: abort with no output afterwards.
    issue(rst_v, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort/in_ready", 64'(in_ready), 64'(1));
    check("abort/out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort/no_stale", 64'(out_valid), 64'(0));

    issue_h(16'h3C00, 16'h3C00, RNE, 16'h3C00, 4'b0000, "h_one_x_one");
    issue_h(16'h7BFF, 16'h4000, RNE, 16'h7C00, 4'b0101, "h_ovf_rne");
    issue_h(16'h7BFF, 16'h4000, RTZ, 16'h7BFF, 4'b0101, "h_ovf_rtz");
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
